// File: rtl/demux_32_bit_4sel_buf_pkg.sv
// Shared definitions for the buffered 1-to-4 distributor: channel count,
// destination select encodings and the select-to-channel decode.
package demux_32_bit_4sel_buf_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  // One-hot channel mask for a destination select.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    case (sel)
      SEL_CH0: oh = 4'b0001;
      SEL_CH1: oh = 4'b0010;
      SEL_CH2: oh = 4'b0100;
      SEL_CH3: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_32_bit_4sel_buf_chan_fifo.sv
// Per-channel synchronous FIFO with registered storage and occupancy count.
// Push is ignored when full and pop is ignored when empty.
module demux_32_bit_4sel_buf_chan_fifo
  import demux_32_bit_4sel_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == {CW{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux_32_bit_4sel_buf.sv
// Buffered 1-to-4 distributor: routes each accepted word into the FIFO of the
// selected channel; every channel drains through its own valid/ready port.
module demux_32_bit_4sel_buf
  import demux_32_bit_4sel_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data_0,
  output logic [WIDTH-1:0]       out_data_1,
  output logic [WIDTH-1:0]       out_data_2,
  output logic [WIDTH-1:0]       out_data_3,
  output logic                   out_valid_0,
  output logic                   out_valid_1,
  output logic                   out_valid_2,
  output logic                   out_valid_3,
  input  logic                   out_ready_0,
  input  logic                   out_ready_1,
  input  logic                   out_ready_2,
  input  logic                   out_ready_3,
  output logic [$clog2(DEPTH):0] count_0,
  output logic [$clog2(DEPTH):0] count_1,
  output logic [$clog2(DEPTH):0] count_2,
  output logic [$clog2(DEPTH):0] count_3,
  output logic                   busy
);

  logic [WIDTH-1:0]       head_s  [NUM_CH];
  logic [$clog2(DEPTH):0] cnt_s   [NUM_CH];
  logic [NUM_CH-1:0]      push_s;
  logic [NUM_CH-1:0]      ready_s;
  logic [NUM_CH-1:0]      full_s;
  logic [NUM_CH-1:0]      empty_s;

  // Readiness looks only at the registered fullness of the target channel,
  // so a same-cycle pop on a full channel never admits a push.
  assign in_ready = rst & ~full_s[in_sel];
  assign push_s   = sel_onehot(in_sel) & {NUM_CH{in_valid & in_ready}};
  assign ready_s  = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_32_bit_4sel_buf_chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s[k]),
      .push_data(in_data),
      .pop      (ready_s[k]),
      .head     (head_s[k]),
      .count    (cnt_s[k]),
      .full     (full_s[k]),
      .empty    (empty_s[k])
    );
  end

  assign out_data_0  = head_s[0];
  assign out_data_1  = head_s[1];
  assign out_data_2  = head_s[2];
  assign out_data_3  = head_s[3];
  assign out_valid_0 = ~empty_s[0];
  assign out_valid_1 = ~empty_s[1];
  assign out_valid_2 = ~empty_s[2];
  assign out_valid_3 = ~empty_s[3];
  assign count_0     = cnt_s[0];
  assign count_1     = cnt_s[1];
  assign count_2     = cnt_s[2];
  assign count_3     = cnt_s[3];
  assign busy        = ~(&empty_s);

endmodule
